// File: rtl/four_bit_addsub_bist.sv
// four_bit_addsub_bist: exhaustive 512-vector self-test of an external 4-bit adder/subtractor
module four_bit_addsub_bist #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       subtract,
  input  logic [3:0] Result,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       first_fail_valid,
  output logic [8:0] first_fail_idx,
  output logic [4:0] first_fail_result
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t     state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [8:0] ffi_q, ffi_d;
  logic [4:0] ffr_q, ffr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] golden;
  logic [4:0] observed;
  assign golden   = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0] ^ {4{idx_q[8]}}} + {4'b0, idx_q[8]};
  assign observed = {Cout, Result};
  // next-state: sweep control, compare on leaving SAMPLE, abort wins over that compare
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    ffr_d   = ffr_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        idx_d   = '0;
        cnt_d   = '0;
        err_d   = '0;
        ffv_d   = 1'b0;
        ffi_d   = '0;
        ffr_d   = '0;
      end
      DRIVE: if (abort) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (cnt_q == 4'(SETTLE - 1)) state_d = SAMPLE;
      else cnt_d = cnt_q + 4'd1;
      SAMPLE: if (abort) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        if (observed != golden) begin
          err_d = err_q + 10'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
            ffr_d = observed;
          end
        end
        if (idx_q == 9'd511) state_d = DONE;
        else begin
          state_d = DRIVE;
          idx_d   = idx_q + 9'd1;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = state_d == DONE;
    pass_d = done_d && (err_d == '0);
  end
  // all state and registered status outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      ffr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffr_q   <= ffr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign subtract          = idx_q[8];
  assign A                 = idx_q[7:4];
  assign B                 = idx_q[3:0];
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_q;
  assign first_fail_valid  = ffv_q;
  assign first_fail_idx    = ffi_q;
  assign first_fail_result = ffr_q;
endmodule

// File: tb/tb_four_bit_addsub_bist.sv
// tb_four_bit_addsub_bist: random fault injection into a modelled adder/subtractor, checked against a sweep model
module tb_four_bit_addsub_bist;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] A, B, Result;
  logic       subtract, Cout, busy, done, pass, ffv;
  logic [9:0] err;
  logic [8:0] ffi;
  logic [4:0] ffr;
  logic [4:0] mask [512];
  logic       stuck = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc;
  always #5 clk = ~clk;
  four_bit_addsub_bist #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .A(A), .B(B), .subtract(subtract), .Result(Result), .Cout(Cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail_idx(ffi), .first_fail_result(ffr)
  );
  function automatic int gold(input logic [8:0] v);
    int a = int'(v[7:4]);
    int b = int'(v[3:0]);
    return v[8] ? a - b + 16 : a + b;
  endfunction
  function automatic logic [4:0] obs(input logic [8:0] v);
    return (5'(gold(v)) ^ mask[v]) & {~stuck, 4'hF};
  endfunction
  assign {Cout, Result} = (5'(gold({subtract, A, B})) ^ mask[{subtract, A, B}]) & {~stuck, 4'hF};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_mask();
    for (int i = 0; i < 512; i++) mask[i] = 5'd0;
  endtask
  task automatic rand_mask();
    for (int i = 0; i < 512; i++) mask[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
  endtask
  task automatic expect_res(input string tag, input int n, input bit full);
    int e = 0;
    int fi = 0;
    int fr = 0;
    bit fv = 1'b0;
    for (int v = 0; v < n; v++) begin
      if (int'(obs(9'(v))) != gold(9'(v))) begin
        e++;
        if (!fv) begin
          fv = 1'b1;
          fi = v;
          fr = int'(obs(9'(v)));
        end
      end
    end
    chk({tag, "_err"}, err, e);
    chk({tag, "_ffv"}, ffv, fv);
    chk({tag, "_ffi"}, ffi, fi);
    chk({tag, "_ffr"}, ffr, fr);
    chk({tag, "_done"}, done, full);
    chk({tag, "_pass"}, pass, full && e == 0);
  endtask
  task automatic run(input string tag, input int abort_at, input int start_at, input bit abort_too, output int c);
    int last = 0;
    int ob = 0;
    int v;
    start = 1'b1;
    abort = abort_too;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_vec0"}, {subtract, A, B}, 0);
    chk({tag, "_clear"}, {err, ffv, ffi, ffr}, 0);
    c = 0;
    while (!done && c < 3000) begin
      abort = (c + 1 == abort_at);
      start = (c + 1 == start_at);
      @(posedge clk);
      #1;
      c++;
      abort = 1'b0;
      start = 1'b0;
      if (busy) begin
        v = int'({subtract, A, B});
        if (v != last) begin
          if (v != last + 1) ob++;
          last = v;
        end
      end
      if (c == abort_at) break;
    end
    chk({tag, "_order"}, ob, 0);
    if (abort_at == 0) begin
      chk({tag, "_cycles"}, c, 1024);
      chk({tag, "_lastvec"}, {subtract, A, B}, 511);
      chk({tag, "_busyend"}, busy, 0);
    end
  endtask
  initial begin
    clear_mask();
    #12;
    chk("rst_outs", {A, B, subtract, busy, done, pass, err, ffv, ffi, ffr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("good", 0, 50, 1'b0, cyc);
    expect_res("good", 512, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_done_done", done, 1);
    chk("abort_done_busy", busy, 0);
    stuck = 1'b1;
    run("stuck", 0, 0, 1'b0, cyc);
    expect_res("stuck", 512, 1'b1);
    chk("stuck_err256", err, 256);
    chk("stuck_ffi31", ffi, 31);
    stuck = 1'b0;
    run("regood", 0, 0, 1'b0, cyc);
    expect_res("regood", 512, 1'b1);
    mask[271] = 5'd4;
    mask[496] = 5'd16;
    run("edge", 0, 0, 1'b0, cyc);
    expect_res("edge", 512, 1'b1);
    chk("edge_ffr", ffr, 5);
    for (int k = 0; k < 3; k++) begin
      rand_mask();
      run("rnd", 0, 0, 1'b0, cyc);
      expect_res("rnd", 512, 1'b1);
    end
    rand_mask();
    mask[3] = 5'd1;
    mask[49] = 5'd2;
    run("abort", 100, 0, 1'b0, cyc);
    chk("abort_outs", {busy, done, subtract, A, B}, 0);
    expect_res("abort", 49, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    clear_mask();
    run("both", 0, 0, 1'b1, cyc);
    expect_res("both", 512, 1'b1);
    rand_mask();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {A, B, subtract, busy, done, pass, err, ffv, ffi, ffr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mask();
    @(negedge clk);
    run("postrst", 0, 0, 1'b0, cyc);
    expect_res("postrst", 512, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/four_bit_addsub_bist.md
FOUR_BIT_ADDSUB_BIST -- requirements
Module: four_bit_addsub_bist

Interface
REQ-001 Parameter SETTLE, default 1: number of cycles each vector is held in DRIVE before it is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock for all state; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  synchronous run request; honoured only in IDLE or DONE.
REQ-005 abort  input  1  synchronous cancel of a run in progress.
REQ-006 A  output  4  operand A driven to the adder/subtractor under test; registered.
REQ-007 B  output  4  operand B driven to the unit under test; registered.
REQ-008 subtract  output  1  mode driven to the unit under test (0 = add, 1 = subtract); registered.
REQ-009 Result  input  4  sum/difference returned by the unit under test.
REQ-010 Cout  input  1  carry-out returned by the unit under test.
REQ-011 busy  output  1  high while in DRIVE or SAMPLE.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  equals done AND (err_count == 0).
REQ-014 err_count  output  10  number of mismatching vectors in the current or last run.
REQ-015 first_fail_valid  output  1  high once any mismatch has been recorded in the current or last run.
REQ-016 first_fail_idx  output  9  vector index of the first mismatch.
REQ-017 first_fail_result  output  5  observed {Cout, Result} at the first mismatch.

Function
REQ-018 States SHALL be IDLE, DRIVE, SAMPLE and DONE; the state register SHALL be encoded as 2 bits.
REQ-019 The vector index idx (9 bits) SHALL map as subtract = idx[8], A = idx[7:4], B = idx[3:0], and SHALL sweep 0..511 in ascending order.
REQ-020 The golden value SHALL be the 5-bit sum {Cout, Result} = A + (B XOR {4{subtract}}) + subtract, with all operands zero-extended to 5 bits.
REQ-021 IDLE or DONE with start=1 at an edge SHALL move to DRIVE, load idx=0 onto A/B/subtract, and clear err_count, first_fail_valid, first_fail_idx and first_fail_result.
REQ-022 DRIVE SHALL last exactly SETTLE cycles and SHALL then move to SAMPLE.
REQ-023 At the edge leaving SAMPLE, the block SHALL compare {Cout, Result} against the golden value for the currently driven vector.
REQ-024 On a mismatch at that edge, err_count SHALL increment by 1, and on the first mismatch of a run the block SHALL capture first_fail_idx and first_fail_result and set first_fail_valid.
REQ-025 On leaving SAMPLE with idx < 511, the block SHALL increment idx, drive the new vector and enter DRIVE.
REQ-026 On leaving SAMPLE with idx = 511, the block SHALL enter DONE with A/B/subtract held at the last vector.
REQ-027 Run length SHALL be 512*(SETTLE+1) cycles from the start edge to done rising; with SETTLE=1 this is 1024 cycles.
REQ-028 start asserted in DRIVE or SAMPLE SHALL be ignored.
REQ-029 abort in DRIVE or SAMPLE SHALL enter IDLE at that edge, drive A=B=0 and subtract=0, and preserve the result registers.
REQ-030 abort SHALL take priority over any compare scheduled at the same edge; that compare SHALL NOT be counted.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 If start and abort are both asserted in IDLE or DONE, start SHALL win.
REQ-033 DONE SHALL hold done and all result outputs until start or reset.
REQ-034 err_count SHALL NOT wrap, since its maximum is 512.

Reset
REQ-035 While rst_n=0, state SHALL be IDLE, and A, B, subtract, busy, done, pass, err_count, first_fail_valid, first_fail_idx and first_fail_result SHALL all be 0.
REQ-036 Reset mid-run SHALL abandon the run with no partial result retained; the first start after rst_n rises SHALL begin at idx=0.

Verification
REQ-037 Correct adder/subtractor in loop, SETTLE=1, start pulse -> busy for 1024 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
REQ-038 Unit under test with Cout stuck at 0 -> done with err_count=256, first_fail_idx=31 (A=0001, B=1111, add), first_fail_result=5'b00000.
REQ-039 Drive checks: idx=496 drives A=1111, B=0000, subtract=1 with golden 5'b11111; idx=271 drives A=0000, B=1111, subtract=1 with golden 5'b00001.
REQ-040 abort 100 cycles after start -> IDLE next edge, busy=0, done=0, outputs A=B=0 and subtract=0; a following start completes with err_count=0.
REQ-041 start pulsed at cycle 50 of a run -> ignored, and completion still occurs at cycle 1024; start in DONE -> err_count and first_fail_* cleared and a new sweep begins.
REQ-042 rst_n low at cycle 300 -> all outputs 0 immediately, without waiting for a clock edge; after release, start yields a full 1024-cycle run.
